// File: rtl/sistema_ram_copier_pkg.sv
// Shared types and constants for the sistema_ram_copier word-copy engine.
package sistema_ram_copier_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/sistema_ram_copier.sv
// Avalon-MM word copier: reads src, writes dst, one word at a time, fixed read latency.
// Optional running checksum of written words when SISTEMA_RAM_COPIER_CSUM_EN is defined.
module sistema_ram_copier
    import sistema_ram_copier_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [ADDR_W-1:0]     len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     address,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W-1:0]     readdata,
    output state_t                dbg_state
`ifdef SISTEMA_RAM_COPIER_CSUM_EN
    ,
    output logic [DATA_W-1:0]     csum
`endif
);

    localparam int         BE_W      = DATA_W / 8;
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("sistema_ram_copier: RD_LAT out of range");
    end

    state_t              state;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W-1:0]   rem_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          wait_cnt;

    assign byteenable = {BE_W{chipselect}};
    assign dbg_state  = state;

    // Outputs are registered alongside the state, so each branch loads the
    // bus values that belong to the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            address    <= '0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
`ifdef SISTEMA_RAM_COPIER_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        rem_q <= len;
`ifdef SISTEMA_RAM_COPIER_CSUM_EN
                        csum  <= '0;
`endif
                        if (len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state      <= RD;
                            busy       <= 1'b1;
                            chipselect <= 1'b1;
                            address    <= src_addr;
                        end
                    end
                end
                RD: begin
                    state      <= WAIT;
                    wait_cnt   <= '0;
                    chipselect <= 1'b0;
                    address    <= '0;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        data_q     <= readdata;
                        state      <= WR;
                        chipselect <= 1'b1;
                        write      <= 1'b1;
                        address    <= dst_q;
                        writedata  <= readdata;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                WR: begin
                    src_q     <= src_q + ADDR_W'(1);
                    dst_q     <= dst_q + ADDR_W'(1);
                    rem_q     <= rem_q - ADDR_W'(1);
                    write     <= 1'b0;
                    writedata <= '0;
`ifdef SISTEMA_RAM_COPIER_CSUM_EN
                    csum      <= csum + data_q;
`endif
                    if (rem_q == ADDR_W'(1)) begin
                        state      <= FIN;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        chipselect <= 1'b0;
                        address    <= '0;
                    end else begin
                        state   <= RD;
                        address <= src_q + ADDR_W'(1);
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sistema_ram_copier.sv
// Bench for sistema_ram_copier: RAM slave model, reference copy model, scoreboard queues.
module tb_sistema_ram_copier;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;
    localparam int CYC_PER_WORD = 2 + RD_LAT;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic [3:0]        byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [2:0]        dbg_state;
`ifdef SISTEMA_RAM_COPIER_CSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    logic [DATA_W-1:0] ram     [0:65535];
    logic [DATA_W-1:0] ref_mem [0:65535];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0]        rd_q[$];
    logic [DATA_W-1:0]        exp_csum;

    int tests;
    int fails;

    sistema_ram_copier #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .byteenable (byteenable),
        .writedata  (writedata),
        .readdata   (readdata),
        .dbg_state  (dbg_state)
`ifdef SISTEMA_RAM_COPIER_CSUM_EN
        ,
        .csum       (csum)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Avalon slave RAM with fixed read latency ----------------
    always @(posedge clk) begin
        if (chipselect && write) ram[address] <= writedata;
        rd_pipe[0] <= (chipselect && !write) ? ram[address] : '0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign readdata = rd_pipe[RD_LAT-1];

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (chipselect) begin
                check("byteenable", 64'(byteenable), 64'hF);
                if (!write) begin
                    if (rd_q.size() == 0) flag_fail("unexpected_read", 64'(address));
                    else check("read_addr", 64'(address), 64'(rd_q.pop_front()));
                end else begin
                    if (exp_q.size() == 0) flag_fail("unexpected_write", 64'({address, writedata}));
                    else check("write_beat", 64'({address, writedata}), 64'(exp_q.pop_front()));
                end
            end else begin
                check("idle_bus", 64'({write, address, writedata}), 64'd0);
            end
        end
    end

    // ---------------- reference model: ascending word copy ----------------
    task automatic model_copy(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] a;
            logic [ADDR_W-1:0] b;
            a = src + ADDR_W'(i);
            b = dst + ADDR_W'(i);
            rd_q.push_back(a);
            exp_q.push_back({b, ref_mem[a]});
            exp_csum = exp_csum + ref_mem[a];
            ref_mem[b] = ref_mem[a];
        end
    endtask

    task automatic set_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ram[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic verify_mem(input logic [ADDR_W-1:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] b;
            b = dst + ADDR_W'(i);
            check("ram_contents", 64'(ram[b]), 64'(ref_mem[b]));
        end
    endtask

    // ---------------- driver: one copy, optional start poke at cycle `poke` ----------------
    task automatic run_copy(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                            input int n_words, input int poke);
        int n;
        int expected;
        bit seen;
        exp_csum = '0;
        model_copy(src, dst, n_words);
        expected = 1 + n_words * CYC_PER_WORD;
        @(negedge clk);
        #1;
        start    = 1'b1;
        src_addr = src;
        dst_addr = dst;
        len      = ADDR_W'(n_words);
        n = 0;
        seen = 1'b0;
        while (!seen && n < expected + 20) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_rise", 64'(busy), 64'(n_words != 0));
            if (done) begin
                seen = 1'b1;
                check("done_cycle", 64'(n), 64'(expected));
                check("busy_in_fin", 64'(busy), 64'd0);
`ifdef SISTEMA_RAM_COPIER_CSUM_EN
                check("csum_at_done", 64'(csum), 64'(exp_csum));
`endif
            end
            #1;
            start    = 1'b0;
            src_addr = ADDR_W'($urandom);
            dst_addr = ADDR_W'($urandom);
            len      = ADDR_W'($urandom_range(1, 8));
            if (n == poke) start = 1'b1;
        end
        if (!seen) flag_fail("done_timeout", 64'(n));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        check("reads_drained", 64'(rd_q.size()), 64'd0);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        verify_mem(dst, n_words);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        tests    = 0;
        fails    = 0;
        exp_csum = '0;
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        for (int i = 0; i < 65536; i++) set_word(ADDR_W'(i), $urandom);

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, chipselect, write, address, writedata}), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        #1;
        reset_n = 1'b1;

        // four known words, RD_LAT=1 -> done 13 cycles after start
        for (int i = 0; i < 4; i++) set_word(ADDR_W'(16'h0010 + i), 32'hA0A0_0000 + DATA_W'(i));
        run_copy(16'h0010, 16'h0040, 4, 0);

        // zero length: straight to FIN, no bus traffic
        run_copy(16'h0080, 16'h0090, 0, 0);

        // source address wraps past the top of the address space
        run_copy(16'hFFFF, 16'h0100, 2, 0);

        // start pulses while busy and while in FIN are ignored
        run_copy(16'h0120, 16'h0140, 3, 4);
        run_copy(16'h0150, 16'h0170, 2, 1 + 2 * CYC_PER_WORD - 1);

        // overlapping ranges with dst > src propagate the first word
        run_copy(16'h0200, 16'h0201, 5, 0);

`ifdef SISTEMA_RAM_COPIER_CSUM_EN
        set_word(16'h0500, 32'hFFFF_FFFF);
        set_word(16'h0501, 32'h0000_0002);
        run_copy(16'h0500, 16'h0520, 2, 0);
        check("csum_wrap", 64'(csum), 64'h1);
`endif

        // reset during WAIT of word 2: word 1 written, word 2 read issued, then abort
        begin
            int n;
            exp_csum = '0;
            model_copy(16'h0020, 16'h0060, 1);
            rd_q.push_back(16'h0021);
            @(negedge clk);
            #1;
            start    = 1'b1;
            src_addr = 16'h0020;
            dst_addr = 16'h0060;
            len      = 16'd4;
            n = 0;
            while (n < 1 + CYC_PER_WORD + 1) begin
                @(negedge clk);
                n++;
                #1;
                start = 1'b0;
            end
            check("abort_in_wait", 64'(dbg_state), 64'd2);
            reset_n = 1'b0;
            #1;
            check("async_reset_outputs", 64'({busy, done, chipselect, write, address, writedata}), 64'd0);
            check("abort_reads", 64'(rd_q.size()), 64'd0);
            check("abort_writes", 64'(exp_q.size()), 64'd0);
            repeat (3) begin
                @(negedge clk);
                check("no_done_in_reset", 64'(done), 64'd0);
            end
            #1;
            reset_n = 1'b1;
            repeat (6) begin
                @(negedge clk);
                check("no_done_after_abort", 64'({busy, done}), 64'd0);
            end
            run_copy(16'h0020, 16'h0060, 4, 0);
        end

        // randomized copies in a shared region, some with stray start pulses
        for (int k = 0; k < 10; k++) begin
            logic [ADDR_W-1:0] s;
            logic [ADDR_W-1:0] d;
            int n_words;
            int poke;
            s = ADDR_W'(16'h0300 + $urandom_range(0, 255));
            d = ADDR_W'(16'h0300 + $urandom_range(0, 255));
            n_words = $urandom_range(0, 12);
            poke = (n_words > 0) ? $urandom_range(1, n_words * CYC_PER_WORD) : 0;
            run_copy(s, d, n_words, poke);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
